// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: control FSM sequencing a shift-add multiplier datapath and its iteration counter
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset (0 = reset)
//   start           level request, accepted only while ready=1
//   counter_is_done iteration counter reached its final value
//   mul_lsb         multiplier LSB, selects an add for the current step
//   ld_regs         pulse: load operand registers
//   init_p          pulse: clear product accumulator
//   InitZcnt        pulse: clear iteration counter
//   cnt             pulse: increment iteration counter
//   add_en          pulse: accumulate multiplicand into product
//   shift_en        pulse: shift product/multiplier right
//   ready           idle and able to accept start
//   done            pulse: result valid
//   perf_cycles     busy-cycle count of the last operation (only with MUL_PERF_CNT_EN)
//
// Build option: define MUL_PERF_CNT_EN to add the saturating perf_cycles counter.
module mul_seq_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PCW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic counter_is_done,
  input  logic mul_lsb,
  output logic ld_regs,
  output logic init_p,
  output logic InitZcnt,
  output logic cnt,
  output logic add_en,
  output logic shift_en,
  output logic ready,
  output logic done
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [PCW-1:0] perf_cycles
`endif
);
  typedef enum logic [2:0] {IDLE, WAIT_REL, LOAD, CHECK, ADD, SHIFT, SETTLE, FIN} state_t;
  // SETTLE stays for SETTLE_CYCLES cycles, so the down-counter is preloaded with one less
  localparam logic [1:0] SLOAD = 2'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  state_t state, nxt;
  logic [1:0] scnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      scnt  <= '0;
    end else begin
      state <= nxt;
      scnt  <= state == SHIFT ? SLOAD : (state == SETTLE && |scnt) ? scnt - 2'd1 : scnt;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? LOAD : IDLE;
      WAIT_REL: nxt = start ? WAIT_REL : IDLE;
      LOAD:     nxt = CHECK;
      CHECK:    nxt = counter_is_done ? FIN : mul_lsb ? ADD : SHIFT;
      ADD:      nxt = SHIFT;
      SHIFT:    nxt = SETTLE_CYCLES > 0 ? SETTLE : CHECK;
      SETTLE:   nxt = |scnt ? SETTLE : CHECK;
      FIN:      nxt = start ? WAIT_REL : IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    ld_regs  = state == LOAD;
    init_p   = state == LOAD;
    InitZcnt = state == LOAD;
    cnt      = state == SHIFT;
    add_en   = state == ADD;
    shift_en = state == SHIFT;
    ready    = state == IDLE;
    done     = state == FIN;
  end
`ifdef MUL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) perf_cycles <= '0;
    else if (state == LOAD) perf_cycles <= '0;
    else if (state != IDLE && state != WAIT_REL && state != FIN && !(&perf_cycles))
      perf_cycles <= perf_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: self-checking bench for mul_seq_ctrl with SETTLE_CYCLES 0 and 1 side by side
module tb_mul_seq_ctrl;
  localparam int PCW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] start = '0, fd = '0, cid, lsb;
  logic [1:0] ld, ip, iz, cn, ad, sh, rdy, dn;
  logic [7:0] mval [2];
  logic [2:0] tgt [2];
  logic [2:0] cq [2];
  logic [7:0] mq [2];
`ifdef MUL_PERF_CNT_EN
  logic [PCW-1:0] perf [2];
`endif
  int checks = 0, errors = 0, cyc = 0;
  int n_ld [2], n_ip [2], n_iz [2], n_cn [2], n_ad [2], n_sh [2], n_dn [2], t_ld [2], t_dn [2];
  logic [1:0] bad = '0;

  for (genvar g = 0; g < 2; g++) begin : gi
    mul_seq_ctrl #(.SETTLE_CYCLES(g), .PCW(PCW)) u (
      .clk(clk), .rst(rst), .start(start[g]), .counter_is_done(cid[g]), .mul_lsb(lsb[g]),
      .ld_regs(ld[g]), .init_p(ip[g]), .InitZcnt(iz[g]), .cnt(cn[g]), .add_en(ad[g]),
      .shift_en(sh[g]), .ready(rdy[g]), .done(dn[g])
`ifdef MUL_PERF_CNT_EN
      , .perf_cycles(perf[g])
`endif
    );
  end

  // datapath stand-ins: iteration counter and multiplier shift register
  always @(posedge clk or negedge rst)
    for (int i = 0; i < 2; i++)
      if (!rst) begin
        cq[i] <= '0;
        mq[i] <= '0;
      end else begin
        if (iz[i]) cq[i] <= '0;
        else if (cn[i]) cq[i] <= cq[i] + 3'd1;
        if (ld[i]) mq[i] <= mval[i];
        else if (sh[i]) mq[i] <= mq[i] >> 1;
      end
  always_comb begin
    cid = '0;
    lsb = '0;
    for (int i = 0; i < 2; i++) begin
      cid[i] = fd[i] | (cq[i] == tgt[i]);
      lsb[i] = mq[i][0];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  initial for (int i = 0; i < 2; i++) begin
    n_ld[i] = 0; n_ip[i] = 0; n_iz[i] = 0; n_cn[i] = 0; n_ad[i] = 0; n_sh[i] = 0; n_dn[i] = 0;
    t_ld[i] = 0; t_dn[i] = 0; mval[i] = '0; tgt[i] = '0;
  end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      n_ld[i] += int'(ld[i]); n_ip[i] += int'(ip[i]); n_iz[i] += int'(iz[i]);
      n_cn[i] += int'(cn[i]); n_ad[i] += int'(ad[i]); n_sh[i] += int'(sh[i]);
      n_dn[i] += int'(dn[i]);
      if (ld[i]) t_ld[i] = cyc;
      if (dn[i]) t_dn[i] = cyc;
      if ((iz[i] & cn[i]) | (ad[i] & sh[i])) bad[i] = 1'b1;
    end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic run(input int s, input logic [7:0] m, input int n, input logic f,
                     input int xl, input int xa, input int xn, input string nm);
    int b_ld, b_ip, b_iz, b_cn, b_ad, b_sh, b_dn, k;
    b_ld = n_ld[s]; b_ip = n_ip[s]; b_iz = n_iz[s]; b_cn = n_cn[s];
    b_ad = n_ad[s]; b_sh = n_sh[s]; b_dn = n_dn[s];
    @(negedge clk);
    mval[s] = m; tgt[s] = 3'(n); fd[s] = f; start[s] = 1'b1;
    k = 0;
    @(negedge clk);
    while (!dn[s] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, int'(k >= 200), 0);
    @(negedge clk);
    start[s] = 1'b0; fd[s] = 1'b0;
    chk({nm, "_latency"}, t_dn[s] - t_ld[s], xl);
    chk({nm, "_adds"}, n_ad[s] - b_ad, xa);
    chk({nm, "_cnts"}, n_cn[s] - b_cn, xn);
    chk({nm, "_shifts"}, n_sh[s] - b_sh, xn);
    chk({nm, "_initz"}, n_iz[s] - b_iz, 1);
    chk({nm, "_loads"}, (n_ld[s] - b_ld) + (n_ip[s] - b_ip), 2);
    chk({nm, "_dones"}, n_dn[s] - b_dn, 1);
    @(negedge clk);
    chk({nm, "_ready"}, int'(rdy[s]), 1);
  endtask

  typedef struct {
    int s; logic [7:0] m; int n; logic f; int lat; int adds; int iters;
  } vec_t;
  vec_t tbl [7];

  initial begin
    int s, n, a, k, b_dn, b_ld;
    logic [7:0] m;
    tbl[0] = '{1, 8'b10101, 5, 1'b0, 20, 3, 5};
    tbl[1] = '{0, 8'h00, 5, 1'b0, 12, 0, 5};
    tbl[2] = '{1, 8'hFF, 3, 1'b1, 2, 0, 0};
    tbl[3] = '{0, 8'hFF, 3, 1'b1, 2, 0, 0};
    tbl[4] = '{0, 8'b11111, 3, 1'b0, 11, 3, 3};
    tbl[5] = '{1, 8'hFF, 7, 1'b0, 30, 7, 7};
    tbl[6] = '{1, 8'hAA, 0, 1'b0, 2, 0, 0};
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(rdy), 3);
    chk("reset_pulses", int'({ld, ip, iz, cn, ad, sh, dn}), 0);
`ifdef MUL_PERF_CNT_EN
    chk("reset_perf", int'(perf[1]), 0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 7; i++)
      run(tbl[i].s, tbl[i].m, tbl[i].n, tbl[i].f, tbl[i].lat, tbl[i].adds, tbl[i].iters,
          $sformatf("tbl%0d", i));
`ifdef MUL_PERF_CNT_EN
    run(1, 8'b10101, 5, 1'b0, 20, 3, 5, "perf_run");
    chk("perf_after_done", int'(perf[1]), 19);
    repeat (4) @(negedge clk);
    chk("perf_hold", int'(perf[1]), 19);
`endif
    for (int i = 0; i < 20; i++) begin
      s = int'($urandom_range(0, 1));
      m = 8'($urandom);
      n = int'($urandom_range(0, 7));
      a = $countones(m & 8'((1 << n) - 1));
      run(s, m, n, 1'b0, 1 + n * (2 + s) + a + 1, a, n, $sformatf("rnd%0d", i));
    end
    // start held long: one operation only, ready low until release
    b_dn = n_dn[0]; b_ld = n_ld[0];
    @(negedge clk);
    mval[0] = 8'h00; tgt[0] = 3'd3; start[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("held_dones", n_dn[0] - b_dn, 1);
    chk("held_loads", n_ld[0] - b_ld, 1);
    chk("held_ready", int'(rdy[0]), 0);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_release_ready", int'(rdy[0]), 1);
    // asynchronous reset in the middle of a shift step
    b_dn = n_dn[1];
    mval[1] = 8'h00; tgt[1] = 3'd5; start[1] = 1'b1;
    k = 0;
    @(negedge clk);
    while (!sh[1] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_shift", int'(sh[1]), 1);
    start[1] = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_async_pulses", int'({ld, ip, iz, cn, ad, sh, dn}), 0);
    chk("rst_async_ready", int'(rdy), 3);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_done", n_dn[1] - b_dn, 0);
    chk("rst_ready_after", int'(rdy[1]), 1);
`ifdef MUL_PERF_CNT_EN
    chk("rst_perf", int'(perf[1]), 0);
`endif
    run(1, 8'b01101, 4, 1'b0, 1 + 4 * 3 + 3 + 1, 3, 4, "post_rst");
    chk("exclusive_pulses", int'(bad), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
